// File: rtl/dir_code_encoder_if.sv
// Handshake bundle for dir_code_encoder: strobe input side, code byte output
// side and the error/occupancy status. The encoder uses the slave modport and
// its driver uses the master modport.
interface dir_code_encoder_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic             Input_1;
  logic             Input_2;
  logic             Input_3;
  logic             Input_4;
  logic [7:0]       Output;
  logic             out_valid;
  logic             out_ready;
  logic             err;
  logic [CNT_W-1:0] drop_count;
  logic             clear_err;
  logic [LVL_W-1:0] level;

  modport slave (
    input  in_valid, Input_1, Input_2, Input_3, Input_4, out_ready, clear_err,
    output in_ready, Output, out_valid, err, drop_count, level
  );

  modport master (
    output in_valid, Input_1, Input_2, Input_3, Input_4, out_ready, clear_err,
    input  in_ready, Output, out_valid, err, drop_count, level
  );
endinterface

// File: rtl/dir_code_encoder.sv
// dir_code_encoder: packs one-hot direction strobes into 8-bit direction code
// bytes (low two bits = code) and buffers them in a small FIFO. Non-one-hot
// inputs are handshaken but discarded, and are recorded in a sticky err flag
// and a saturating drop counter.
// Optional macro DIR_CODE_PARITY_EN: when defined, Output[7] carries even
// parity over the code bits (codes 0x00, 0x81, 0x82, 0x03).
module dir_code_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  dir_code_encoder_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       out_q, out_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [3:0]       strobes;
  logic             one_hot;
  logic [1:0]       code;
  logic             parity;
  logic [7:0]       push_byte;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_d;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             push;
  logic             bad;
  logic             pop;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx_d;

  assign strobes = {bus.Input_4, bus.Input_3, bus.Input_2, bus.Input_1};
  assign one_hot = (strobes != 4'd0) && ((strobes & (strobes - 4'd1)) == 4'd0);

  // Map the single active strobe to its direction code.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    code = 2'd0;
    unique case (strobes)
      4'b0010: code = 2'd1;
      4'b0100: code = 2'd2;
      4'b1000: code = 2'd3;
      default: code = 2'd0;
    endcase
  end

`ifdef DIR_CODE_PARITY_EN
  assign parity = code[0] ^ code[1];
`else
  assign parity = 1'b0;
`endif

  assign push_byte = {parity, 5'b00000, code};

  // Occupancy and handshakes depend on registered pointers only.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign accept    = bus.in_valid && in_ready;
  assign push      = accept && one_hot;
  assign bad       = accept && !one_hot;
  assign pop       = out_valid && bus.out_ready;
  assign wr_idx    = wr_ptr_q[AW-1:0];

  // Next pointers, next head byte and next error state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;
    rd_idx_d = rd_ptr_d[AW-1:0];

    // The new head is the byte being written this cycle when it lands in the
    // head slot (empty FIFO, or a push+pop that leaves one byte).
    if (level_d == '0) begin
      out_d = 8'h00;
    end else if (push && (wr_idx == rd_idx_d)) begin
      out_d = push_byte;
    end else begin
      out_d = mem_q[rd_idx_d];
    end

    // A malformed accept wins over a simultaneous clear.
    err_d  = err_q;
    drop_d = drop_q;
    if (bad) begin
      err_d  = 1'b1;
      drop_d = bus.clear_err ? CNT_W'(1)
             : (drop_q == CNT_MAX) ? drop_q : drop_q + CNT_W'(1);
    end else if (bus.clear_err) begin
      err_d  = 1'b0;
      drop_d = '0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= 8'h00;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale entries are never visible
    // because Output is forced to 0x00 whenever the FIFO is empty.
    if (push) begin
      mem_q[wr_idx] <= push_byte;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.Output     = out_q;
  assign bus.err        = err_q;
  assign bus.drop_count = drop_q;
  assign bus.level      = level;

endmodule

// File: tb/tb_dir_code_encoder.sv
// Self-checking bench for dir_code_encoder: directed scenarios plus random
// traffic, checked by a behavioural model feeding a scoreboard queue that a
// separate monitor drains whenever the encoder presents a byte.
module tb_dir_code_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q [$];
  int         m_level;
  int         m_drop;
  logic       m_err;

  dir_code_encoder_if #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  dir_code_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected byte for a direction index 0..3.
  function automatic logic [7:0] enc(input int dir);
    logic [7:0] b;
    b = 8'(dir);
`ifdef DIR_CODE_PARITY_EN
    if (dir == 1 || dir == 2) b = b + 8'h80;
`endif
    return b;
  endfunction

  function automatic int dir_of(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic set_strobes(input logic [3:0] s);
    bus.Input_1 = s[0];
    bus.Input_2 = s[1];
    bus.Input_3 = s[2];
    bus.Input_4 = s[3];
  endtask

  // Present s until accepted (bounded); returns the number of edges waited.
  task automatic send(input logic [3:0] s, input int budget, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    set_strobes(s);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waited = n;
      if (acc) break;
    end
    check("send_accept", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Model: tracks occupancy, error state and expected bytes at a level of
  // whole transactions; compares status outputs every cycle.
  always @(negedge clk) begin
    logic [3:0] s;
    logic acc, pop, good;
    if (!rst) begin
      exp_q.delete();
      m_level = 0;
      m_err   = 1'b0;
      m_drop  = 0;
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_level",     32'(bus.level),     32'd0);
      check("rst_output",    32'(bus.Output),    32'd0);
      check("rst_err",       32'(bus.err),       32'd0);
      check("rst_drop",      32'(bus.drop_count),32'd0);
    end else begin
      check("level",     32'(bus.level),      32'(m_level));
      check("in_ready",  32'(bus.in_ready),   32'(m_level != DEPTH));
      check("out_valid", 32'(bus.out_valid),  32'(m_level != 0));
      check("err",       32'(bus.err),        32'(m_err));
      check("drop_count",32'(bus.drop_count), 32'(m_drop));
      s    = {bus.Input_4, bus.Input_3, bus.Input_2, bus.Input_1};
      acc  = bus.in_valid && (m_level != DEPTH);
      pop  = (m_level != 0) && bus.out_ready;
      good = ($countones(s) == 1);
      if (acc && good) begin
        exp_q.push_back(enc(dir_of(s)));
        m_level++;
      end
      if (pop) m_level--;
      if (acc && !good) begin
        m_err  = 1'b1;
        m_drop = bus.clear_err ? 1 : ((m_drop == MAXCNT) ? MAXCNT : m_drop + 1);
      end else if (bus.clear_err) begin
        m_err  = 1'b0;
        m_drop = 0;
      end
    end
  end

  // Monitor: compares the presented byte against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_data", 32'(bus.Output), 32'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("out_idle", 32'(bus.Output), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [3:0] s;
    logic [7:0] first;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear_err = 1'b0;
    set_strobes(4'b0000);
    #1 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Each direction in turn with the sink always ready: one-cycle latency.
    bus.out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      send(4'(1 << d), 4, w);
      check("lat_valid", 32'(bus.out_valid), 32'd1);
      check("lat_data",  32'(bus.Output),    32'(enc(d)));
    end
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Fill with the sink stalled, then hold a fifth byte against a full FIFO.
    bus.out_ready = 1'b0;
    first = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      s = 4'(1 << $urandom_range(3));
      if (i == 0) first = enc(dir_of(s));
      send(s, 4, w);
    end
    bus.in_valid = 1'b1;
    set_strobes(4'(1 << $urandom_range(3)));
    repeat (3) begin
      @(posedge clk); #1;
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_level",    32'(bus.level),    32'(DEPTH));
      check("full_head",     32'(bus.Output),   32'(first));
    end
    bus.out_ready = 1'b1;
    send({bus.Input_4, bus.Input_3, bus.Input_2, bus.Input_1}, 6, w);
    check("stall_accept_edge", 32'(w), 32'd1);
    repeat (DEPTH + 2) begin @(posedge clk); #1; end

    // Malformed inputs, clear, and clear colliding with a malformed input.
    send(4'b0000, 4, w);
    send(4'b0101, 4, w);
    check("bad_err",   32'(bus.err),        32'd1);
    check("bad_drop",  32'(bus.drop_count), 32'd2);
    check("bad_level", 32'(bus.level),      32'd0);
    bus.clear_err = 1'b1;
    @(posedge clk); #1;
    bus.clear_err = 1'b0;
    check("clr_err",  32'(bus.err),        32'd0);
    check("clr_drop", 32'(bus.drop_count), 32'd0);
    bus.clear_err = 1'b1;
    send(4'b1100, 4, w);
    bus.clear_err = 1'b0;
    check("clr_bad_err",  32'(bus.err),        32'd1);
    check("clr_bad_drop", 32'(bus.drop_count), 32'd1);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      s = 4'($urandom_range(15));
      if ($countones(s) == 1) s = 4'b1111;
      send(s, 4, w);
    end
    check("sat_drop", 32'(bus.drop_count), 32'(MAXCNT));
    check("sat_err",  32'(bus.err),        32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.out_ready = ($urandom_range(1) == 1);
      bus.clear_err = ($urandom_range(19) == 0);
      if ($urandom_range(9) < 8) set_strobes(4'(1 << $urandom_range(3)));
      else set_strobes(4'($urandom_range(15)));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.clear_err = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) begin @(posedge clk); #1; end

    // Asynchronous reset with bytes buffered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'(1 << $urandom_range(3)), 4, w);
    check("pre_rst_level", 32'(bus.level), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_level",     32'(bus.level),     32'd0);
    check("arst_output",    32'(bus.Output),    32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    send(4'b0100, 4, w);
    check("post_rst_data", 32'(bus.Output), 32'(enc(2)));
    repeat (3) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dir_code_encoder.md
Name: dir_code_encoder

Overview:
- Reverse of the direction decoder in the AOC Day3 translator. Takes one-hot direction strobes (Input_1..Input_4) and packs each into an 8-bit direction code byte; the byte's low 2 bits are exactly the code the decoder consumes.
- Sits between the path parser and the wire-path store.
- Provides valid/ready handshakes on both sides, a small FIFO for decoupling, and sticky error reporting for malformed (non-one-hot) inputs.

Parameters:
FIFO_DEPTH, 4, number of code bytes buffered; power of two, ≥2.
CNT_W, 8, width of the saturating drop counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
in_valid  input  1  direction strobe set is valid this cycle.
in_ready  output  1  encoder can accept an input this cycle.
Input_1  input  1  direction 0 strobe.
Input_2  input  1  direction 1 strobe.
Input_3  input  1  direction 2 strobe.
Input_4  input  1  direction 3 strobe.
Output  output  8  encoded direction byte at FIFO head.
out_valid  output  1  Output holds a valid byte.
out_ready  input  1  downstream consumes Output this cycle.
err  output  1  sticky malformed-input flag.
drop_count  output  CNT_W  number of malformed inputs discarded, saturating.
clear_err  input  1  synchronous clear of err and drop_count.
level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Encoding:
  - Input_1→0x00, Input_2→0x01, Input_3→0x02, Input_4→0x03.
  - Output[1:0] = code; Output[7:2] = 0, except bit 7 when the optional feature below is enabled.
- Reset (rst low, async):
  - FIFO pointers and level = 0; out_valid = 0; Output = 0x00; err = 0; drop_count = 0.
  - in_ready = 1 during and after reset.
- Accept: a transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = (level != FIFO_DEPTH). It is a function of registered state only, with no combinational path from out_ready.
  - Well-formed input (exactly one strobe high): the code byte is written at the write pointer and level increments.
  - Malformed input (zero, or two or more, strobes high): the handshake completes but nothing is written. err is set to 1. drop_count increments and saturates at 2^CNT_W−1.
- Latency: a byte accepted at edge N is visible with out_valid = 1 after edge N (one cycle), provided the FIFO was empty.
- Drain: a pop occurs when out_valid && out_ready.
  - out_valid = (level != 0).
  - Output = FIFO head and is held stable while out_valid && !out_ready.
  - Output = 0x00 when empty.
- Simultaneous push and pop (well-formed input):
  - level is unchanged.
  - Order is preserved; the pushed byte goes behind the popped head.
- Wrap-around: pointers are modulo FIFO_DEPTH, with an extra wrap bit to distinguish full from empty.
- Full: in_ready = 0; in_valid is ignored; no state change on the input side.
- Empty: out_ready is ignored.
- clear_err in the same cycle as a malformed accept: err ends at 1 and drop_count ends at 1 (the new event wins over the clear).
- clear_err does not affect FIFO contents.
- Reset asserted mid-stream: all buffered bytes are discarded immediately and the outputs return to reset values.
- Output, err and drop_count are registered. Output comes directly from storage; no combinational path from any Input_n to Output.

Optional Feature:
DIR_CODE_PARITY_EN
- Defined: Output[7] = Output[0] XOR Output[1] (even parity over the byte). Codes become 0x00, 0x81, 0x82, 0x03. Bits [6:2] remain 0.
- Undefined: Output[7] = 0. Codes are 0x00–0x03 exactly.
- The decoder ignores bits [7:2], so it is compatible in both cases.

Test Plan:
- Reset, then strobes Input_1, Input_2, Input_3, Input_4 on consecutive cycles with out_ready = 1 → Output sequence 0x00, 0x01, 0x02, 0x03, each appearing one cycle after its accept. With parity enabled: 0x00, 0x81, 0x82, 0x03.
- out_ready = 0, push 5 well-formed inputs with FIFO_DEPTH = 4 → in_ready drops after the 4th push and level = 4. The 5th input stalls; Output stays 0x00 (first byte) throughout.
- Full FIFO, out_ready = 1 with in_valid held → one pop per cycle; the stalled 5th byte is accepted on the cycle after the first pop; order is preserved.
- Inputs 4'b0000 then 4'b0101 → no bytes written, err = 1, drop_count = 2. Then clear_err alone → err = 0, drop_count = 0. Then clear_err plus a malformed input together → err = 1, drop_count = 1.
- 300 malformed inputs with CNT_W = 8 → drop_count saturates at 255; err = 1.
- 3 bytes buffered, then rst pulsed low mid-cycle → out_valid = 0, level = 0, Output = 0x00 immediately (async). After rst goes high, in_ready = 1.
